// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide on operand magnitudes, with the sign fix-up applied when the result is written.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3_q;
  logic              neg_q;   // product / quotient sign
  logic              rneg_q;  // remainder sign
  logic [XLEN-1:0]   op_q;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;     // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]   result_q;

  // Operand decode for the launch cycle
  logic            a_sgn, b_sgn, a_neg, b_neg, is_div;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn    = is_div ? !funct3[0] : (funct3[1:0] == 2'b01);
    a_neg    = a_sgn && rs1_data[XLEN-1];
    b_neg    = b_sgn && rs2_data[XLEN-1];
    mag_a    = a_neg ? -rs1_data : rs1_data;
    mag_b    = b_neg ? -rs2_data : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = funct3[1] ? rs1_data : '1;
    else          special_res = funct3[1] ? '0 : INT_MIN;
  end

  // One iteration of the selected algorithm, plus the signed result it would produce
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] acc_nxt, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? op_q : '0)};
    div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, op_q};
    if (f3_q[2])
      acc_nxt = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    prod_fix = neg_q  ? -acc_nxt : acc_nxt;
    quo_fix  = neg_q  ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_fix  = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (f3_q[2])                final_res = f3_q[1] ? rem_fix : quo_fix;
    else if (f3_q[1:0] == 2'b00) final_res = prod_fix[XLEN-1:0];
    else                        final_res = prod_fix[2*XLEN-1:XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      op_q     <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            f3_q   <= funct3;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            op_q   <= is_div ? mag_b : mag_a;
            acc    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            cnt    <= '0;
            if (special) begin
              result_q <= special_res;
              state    <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            result_q <= final_res;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign stall_req = ((state == ST_IDLE) && start && !flush) || (state == ST_CALC);
  assign done      = (state == ST_DONE) && !flush;
  assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, flush/reset aborts,
// and randomized ops compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (f3)
      F_MUL:    begin p = sa * sb; return p[31:0];  end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * ub; return p[63:32]; end
      F_MULHU:  begin p = ua * ub; return p[63:32]; end
      F_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
      F_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; q = ua / ub; return q[31:0]; end
      F_REM:    begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      default:  begin if (b == 0) return a; q = ua % ub; return q[31:0]; end
    endcase
  endfunction

  // Launch one op at a negedge and follow it to completion; optionally poke start while busy.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input string tag);
    logic [31:0] exp;
    int lat, stall_cnt, k;
    bit seen;
    exp = model(f3, a, b);
    lat = is_special(f3, a, b) ? 1 : 33;
    @(negedge clk);
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'b0, done}, 32'd0);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
    #1;
    stall_cnt = stall_req ? 1 : 0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom; funct3 = 3'($urandom);
      end
      if (done) begin
        seen = 1'b1;
        check({tag, "_latency"}, k, lat);
        check({tag, "_stall_cnt"}, stall_cnt, lat);
        check({tag, "_stall_in_done"}, {31'b0, stall_req}, 32'd0);
        check({tag, "_result"}, result, exp);
      end else begin
        if (stall_req) stall_cnt++;
        if (poke && k == 5) begin
          start = 1'b1; funct3 = F_DIVU; rs1_data = 32'd100; rs2_data = 32'd7;
        end
        if (poke && k == 6) start = 1'b0;
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] prev, a, b;
    int dones;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; rs1_data = '0; rs2_data = '0;
    #12;
    check("rst_busy",   {31'b0, busy},      32'd0);
    check("rst_stall",  {31'b0, stall_req}, 32'd0);
    check("rst_done",   {31'b0, done},      32'd0);
    check("rst_result", result,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(F_MUL,    32'd7,         32'hFFFF_FFFD, 1'b0, "mul_neg");
    run_op(F_MULH,   32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min");
    run_op(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu_max");
    run_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_max");
    run_op(F_MUL,    32'h0001_0000, 32'h0001_0000, 1'b0, "mul_wrap");
    run_op(F_DIV,    32'hFFFF_FFEC, 32'd3,         1'b0, "div_neg");
    run_op(F_REM,    32'hFFFF_FFEC, 32'd3,         1'b0, "rem_neg");
    run_op(F_DIVU,   32'd20,        32'd3,         1'b0, "divu");
    run_op(F_REMU,   32'd20,        32'd3,         1'b0, "remu");
    run_op(F_DIV,    32'd20,        32'hFFFF_FFFD, 1'b0, "div_negb");
    run_op(F_DIV,    32'd5,         32'd0,         1'b0, "div_zero");
    run_op(F_REM,    32'd5,         32'd0,         1'b0, "rem_zero");
    run_op(F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
    run_op(F_MULHU,  32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "busy_start");

    // Flush at iteration 10, with start raised alongside it
    prev = model(F_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    start = 1'b1; funct3 = F_MUL; rs1_data = 32'd9; rs2_data = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    flush = 1'b0; start = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("flush_no_done", dones, 0);
    check("flush_result",  result, prev);

    // start together with flush in IDLE is ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = F_DIV; rs1_data = 32'd5; rs2_data = 32'd0;
    #1;
    check("sf_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("sf_busy", {31'b0, busy}, 32'd0);
    check("sf_done", {31'b0, done}, 32'd0);

    // Reset at iteration 20
    @(negedge clk);
    start = 1'b1; funct3 = F_MUL; rs1_data = 32'd11; rs2_data = 32'd13;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   {31'b0, busy},      32'd0);
    check("mid_rst_stall",  {31'b0, stall_req}, 32'd0);
    check("mid_rst_done",   {31'b0, done},      32'd0);
    check("mid_rst_result", result,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(F_MUL, 32'd3, 32'd4, 1'b0, "post_rst_mul");

    // Randomized ops, biased towards the boundary operands
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h0;
        1:       a = 32'h8000_0000;
        2:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h8000_0000;
        3:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(3'($urandom_range(0, 7)), a, b, ($urandom_range(0, 3) == 0), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
